ps2_rx_hist: RTL and testbench

Parametrised PS/2 keyboard receiver that filters the PS/2 clock and deserialises 11-bit device-to-host frames. It checks the start, parity and stop bits and keeps a shift history of the last DEPTH accepted scan-code bytes. It sits between the board PS/2 pins and the hex-display encoder, which consumes `code`. It also reports a per-byte valid strobe and a frame-error strobe to downstream logic.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_clk_filter.sv | 47 ++++
 rtl/ps2_rx_hist.sv | 162 ++++++++++++++++
 tb/tb_ps2_rx_hist.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and constants: FSM state encoding, frame geometry
// and the odd-parity helper used by the frame check.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  // Parity bit that makes the data byte plus parity carry an odd number of ones
  function automatic logic oddParity(input logic [PS2_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchroniser plus stability filter for the raw PS/2 clock pin.
// The filtered level only follows the pin after DEB_CYCLES consecutive differing samples.
module ps2_clk_filter #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2clk_i,
  output logic filt_o
);

  localparam int CntW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic            sync1Q, sync2Q;
  logic            filtQ, filtD;
  logic [CntW-1:0] cntQ, cntD;

  // The idle PS/2 line is high, so every stage resets to 1 to avoid a false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1Q <= 1'b1;
      sync2Q <= 1'b1;
      filtQ  <= 1'b1;
      cntQ   <= '0;
    end else begin
      sync1Q <= ps2clk_i;
      sync2Q <= sync1Q;
      filtQ  <= filtD;
      cntQ   <= cntD;
    end
  end

  always_comb begin
    filtD = filtQ;
    cntD  = '0;
    if (sync2Q != filtQ) begin
      if (cntQ == CntW'(DEB_CYCLES - 1)) begin
        filtD = sync2Q;
      end else begin
        cntD = cntQ + CntW'(1);
      end
    end
  end

  assign filt_o = filtQ;

endmodule

// File: rtl/ps2_rx_hist.sv
// PS/2 keyboard receiver: deserialises 11-bit frames and keeps a history of accepted bytes.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not match.
module ps2_rx_hist
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 2,
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ps2clk,
  input  logic                 ps2data,
  output logic [8*DEPTH-1:0]   code,
  output logic [7:0]           byte_data,
  output logic                 byte_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int ToW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DataLastIdx = PS2_FRAME_BITS - 4;

  logic                     filtClk;
  logic                     dSync1Q, dSync2Q;
  logic                     lastFiltQ, fallQ;
  ps2_state_e               stateQ, stateD;
  logic [2:0]               bitCntQ, bitCntD;
  logic [PS2_DATA_BITS-1:0] shiftQ, shiftD;
  logic [ToW-1:0]           toutQ, toutD;
  logic [8*DEPTH-1:0]       codeQ, codeShifted;
  logic [7:0]               byteQ;
  logic                     validQ, errQ;
  logic                     acceptD, rejectD, timeoutD, frameOk;

  ps2_clk_filter #(
    .DEB_CYCLES(DEB_CYCLES)
  ) uClkFilter (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2clk_i(ps2clk),
    .filt_o  (filtClk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dSync1Q   <= 1'b1;
      dSync2Q   <= 1'b1;
      lastFiltQ <= 1'b1;
      fallQ     <= 1'b0;
    end else begin
      dSync1Q   <= ps2data;
      dSync2Q   <= dSync1Q;
      lastFiltQ <= filtClk;
      fallQ     <= lastFiltQ & ~filtClk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  // A fall in the same cycle as the timeout wins, so timeoutD already excludes it
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (fallQ && !dSync2Q) stateD = DATA;
      DATA:    if (fallQ && bitCntQ == 3'(DataLastIdx)) stateD = PARITY;
      PARITY:  if (fallQ) stateD = STOP;
      STOP:    if (fallQ) stateD = IDLE;
      default: stateD = IDLE;
    endcase
    if (timeoutD) stateD = IDLE;
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parityQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         parityQ <= 1'b0;
    else if (fallQ && stateQ == PARITY) parityQ <= dSync2Q;
  end

  assign frameOk = dSync2Q && (parityQ == oddParity(shiftQ));
`else
  assign frameOk = dSync2Q;
`endif

  always_comb begin
    timeoutD = (stateQ != IDLE) && !fallQ && (toutQ == ToW'(TIMEOUT_CYCLES));
    acceptD  = 1'b0;
    rejectD  = 1'b0;
    if (stateQ == STOP && fallQ) begin
      acceptD = frameOk;
      rejectD = !frameOk;
    end
  end

  always_comb begin
    shiftD  = shiftQ;
    bitCntD = bitCntQ;
    if (stateQ == IDLE || fallQ || timeoutD) toutD = '0;
    else                                     toutD = toutQ + ToW'(1);
    if (fallQ) begin
      unique case (stateQ)
        IDLE: begin
          if (!dSync2Q) begin
            shiftD  = '0;
            bitCntD = '0;
          end
        end
        DATA: begin
          shiftD  = {dSync2Q, shiftQ[PS2_DATA_BITS-1:1]};
          bitCntD = bitCntQ + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftQ  <= '0;
      bitCntQ <= '0;
      toutQ   <= '0;
    end else begin
      shiftQ  <= shiftD;
      bitCntQ <= bitCntD;
      toutQ   <= toutD;
    end
  end

  if (DEPTH == 1) begin : gHistOne
    assign codeShifted = shiftQ;
  end else begin : gHistMany
    assign codeShifted = {codeQ[8*DEPTH-9:0], shiftQ};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codeQ  <= '0;
      byteQ  <= '0;
      validQ <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      if (acceptD) begin
        codeQ <= codeShifted;
        byteQ <= shiftQ;
      end
      validQ <= acceptD;
      errQ   <= rejectD | timeoutD;
    end
  end

  assign code       = codeQ;
  assign byte_data  = byteQ;
  assign byte_valid = validQ;
  assign frame_err  = errQ;
  assign busy       = (stateQ != IDLE);

endmodule

// File: tb/tb_ps2_rx_hist.sv
// Self-checking bench for ps2_rx_hist: table of frames plus timeout, glitch and reset sequences.
// Expected byte/error events are queued as frames are driven and popped when the DUT pulses.
module tb_ps2_rx_hist;

  localparam int DEPTH = 2;
  localparam int DEB   = 4;
  localparam int TOUT  = 200;
  localparam int HALF  = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2clk = 1'b1;
  logic        ps2data = 1'b1;
  logic [15:0] code;
  logic [7:0]  byte_data;
  logic        byte_valid, frame_err, busy;

  ps2_rx_hist #(
    .DEPTH(DEPTH),
    .DEB_CYCLES(DEB),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ps2clk(ps2clk),
    .ps2data(ps2data),
    .code(code),
    .byte_data(byte_data),
    .byte_valid(byte_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isErr;
    logic [7:0]  data;
    logic [15:0] code;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       expAccept;
  } vec_t;

  exp_t        expQ[$];
  exp_t        monE;
  vec_t        vecs[8];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] codeModel = '0;
  logic [7:0]  byteModel = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    ps2data = b;
    waitCycles(HALF);
    ps2clk = 1'b0;
    waitCycles(HALF);
    ps2clk = 1'b1;
  endtask

  task automatic glitch();
    waitCycles(5);
    ps2clk = 1'b0;
    waitCycles(3);
    ps2clk = 1'b1;
  endtask

  task automatic expectFrame(input logic accept, input logic [7:0] d);
    exp_t e;
    if (accept) begin
      codeModel = {codeModel[7:0], d};
      byteModel = d;
    end
    e.isErr = !accept;
    e.data  = byteModel;
    e.code  = codeModel;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stop,
                               input logic expAccept, input int glitchAt);
    expectFrame(expAccept, d);
    sendBit(1'b0);
    if (glitchAt == 0) glitch();
    for (int i = 0; i < 8; i++) begin
      sendBit(d[i]);
      if (glitchAt == i + 1) glitch();
    end
    sendBit(par);
    sendBit(stop);
    waitCycles(HALF);
  endtask

  task automatic waitDrained(input string name, input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      waitCycles(1);
      n++;
    end
    checkOutput(name, expQ.size(), 0);
  endtask

  // Scoreboard side: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid && frame_err) begin
        checks++;
        failures++;
        $display("[TB] FAIL both_pulses: byte_valid=%0b frame_err=%0b required not both", byte_valid, frame_err);
      end else if (byte_valid || frame_err) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event: byte_valid=%0b frame_err=%0b required none", byte_valid, frame_err);
        end else begin
          monE = expQ.pop_front();
          checkOutput("event_is_err", 32'(frame_err), 32'(monE.isErr));
          checkOutput("byte_data", 32'(byte_data), 32'(monE.data));
          checkOutput("code", 32'(code), 32'(monE.code));
        end
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b1};
`ifdef PS2_PARITY_CHECK_EN
    vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b0};
`else
    vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b1};
`endif
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{8'h55, 1'b1, 1'b0, 1'b0};

    waitCycles(3);
    checkOutput("rst_code", 32'(code), 0);
    checkOutput("rst_byte_data", 32'(byte_data), 0);
    checkOutput("rst_byte_valid", 32'(byte_valid), 0);
    checkOutput("rst_frame_err", 32'(frame_err), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    waitCycles(5);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].expAccept, -1);
      waitDrained("frame_drained", 100);
      checkOutput("busy_after_frame", 32'(busy), 0);
      if (i == 2) checkOutput("code_after_three", 32'(code), 32'h0000F01C);
    end

    // Partial frame abandoned mid-way must time out
    expectFrame(1'b0, 8'h00);
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(i[0]);
    checkOutput("busy_mid_frame", 32'(busy), 1);
    waitDrained("timeout_event", TOUT + 200);
    checkOutput("busy_after_timeout", 32'(busy), 0);
    applyStimulus(8'h32, 1'b0, 1'b1, 1'b1, -1);
    waitDrained("after_timeout_drained", 100);
    checkOutput("code_low_32", 32'(code[7:0]), 32'h32);

    ps2clk = 1'b0;
    waitCycles(2);
    ps2clk = 1'b1;
    waitCycles(20);
    checkOutput("busy_idle_glitch", 32'(busy), 0);
    applyStimulus(8'h1C, 1'b0, 1'b1, 1'b1, 3);
    waitDrained("glitch_frame_drained", 100);

    sendBit(1'b0);
    for (int i = 0; i < 5; i++) sendBit(i[0] ^ i[1]);
    checkOutput("busy_before_reset", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_code", 32'(code), 0);
    checkOutput("async_rst_byte_data", 32'(byte_data), 0);
    checkOutput("async_rst_byte_valid", 32'(byte_valid), 0);
    checkOutput("async_rst_frame_err", 32'(frame_err), 0);
    checkOutput("async_rst_busy", 32'(busy), 0);
    expQ.delete();
    codeModel = '0;
    byteModel = '0;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(5);
    applyStimulus(8'h1C, 1'b0, 1'b1, 1'b1, -1);
    waitDrained("post_reset_drained", 100);
    checkOutput("post_reset_code", 32'(code), 32'h0000001C);

    waitCycles(10);
    checkOutput("queue_empty_end", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
